model_arbiter: RTL and testbench
================================

# model_arbiter

Round-robin controller that shares a single combinational `model` datapath instance (8-bit `in1` → 8-bit `out1`) among `NREQ` requesters. It grants one requester at a time and drives that requester's operand onto the shared `model` input. It holds the operand for a programmable settle time, captures the datapath output into a result register, and returns it with a one-cycle completion pulse to the granted requester. It sits between the requester blocks and the one `model` instance, which is instantiated outside this block.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `WIDTH`, 8: operand/result width; must match `model` (8).
- `SETTLE`, 2: cycles `model_in` is held stable before `model_out` is sampled; legal range 1..15.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  NREQ  level request, one bit per requester.
- `req_data`  in  NREQ*WIDTH  packed operands; requester i at bits [i*WIDTH +: WIDTH].
- `gnt`  out  NREQ  one-hot grant, held for the whole transaction.
- `done`  out  NREQ  one-cycle completion pulse to the granted requester.
- `result`  out  WIDTH  captured `model_out`; valid in the `done` cycle, held until the next capture.
- `busy`  out  1  high while a transaction is in flight (`gnt` != 0).
- `model_in`  out  WIDTH  drives the shared `model` `in1`.
- `model_out`  in  WIDTH  from the shared `model` `out1`.

## Operation
- FSM states: IDLE, WAIT.
- IDLE:
  - If `req` is 0, stay in IDLE.
  - Otherwise pick the winner: the first set `req` bit searching upward from `ptr`, wrapping modulo NREQ.
  - Register `gnt` = onehot(winner), `model_in` = `req_data[winner]`, `cnt` = SETTLE, `busy` = 1. Go to WAIT.
- WAIT:
  - Each edge, `cnt` decrements.
  - At the edge where `cnt` == 1:
    - `result` <= `model_out`.
    - `done[winner]` <= 1 for one cycle.
    - `gnt` <= 0, `busy` <= 0.
    - `ptr` <= (winner+1) mod NREQ.
    - Go to IDLE.
- `model_in` holds its last value after completion; it changes only at a grant.
- `req_data` is sampled only at the grant edge. Changes during WAIT do not affect the transaction.
- Dropping `req` during WAIT does not abort: the transaction completes and `done` still pulses.
- A requester wanting no further transaction deasserts `req` in its `done` cycle. If `req` is still high at the next edge, that is a new request and competes under round-robin.
- `ptr` advances only on completion. A lone persistent requester is granted repeatedly.
- Reset values: state IDLE, `ptr` 0, `cnt` 0, `gnt` 0, `done` 0, `result` 0, `model_in` 0, `busy` 0.
- Reset asserted mid-WAIT aborts immediately:
  - All outputs return to reset values asynchronously.
  - No `done` is issued for the aborted transaction.
  - After release, arbitration restarts from requester 0.

## Timing
- All outputs are registered. There are no combinational paths from `req`/`req_data`/`model_out` to any output.
- Request sampled at edge E0 → `gnt`, `busy`, and `model_in` valid after E0.
- `result` and `done` valid after edge E0+SETTLE; `gnt` and `busy` drop at that same edge.
- The earliest next grant is at edge E0+SETTLE+1.
- Per-transaction occupancy is SETTLE+1 cycles. Back-to-back throughput is one result per SETTLE+1 cycles.
- `model_out` is sampled after exactly SETTLE cycles of stable `model_in`. This is the only datapath timing assumption.
- Arbitration latency: worst-case wait for a requester is (NREQ-1)*(SETTLE+1) cycles after its first sampled `req`.

## Test plan
Default parameters unless stated; a reference `model` instance provides the expected `result`.

1. **Single request.**
   - Stimulus: `req`=4'b0010, `req_data[1]`=8'h05, sampled at edge 0.
   - Required: `gnt`=4'b0010 and `model_in`=8'h05 after edge 0; `done`=4'b0010 for exactly one cycle after edge 2; `result` equals `model`(8'h05); `busy` is 1 only during cycles 1–2.
2. **All requesters held high.**
   - Stimulus: all four `req` bits held with operands 8'h01..8'h04.
   - Required: grants in order 0,1,2,3,0 at edges 0,3,6,9,12; each `result` matches its operand's `model` value.
3. **Fairness.**
   - Stimulus: `req[0]` held continuously; `req[2]` asserted at cycle 1.
   - Required: grant sequence 0,2,0,2; `req[0]` is never granted twice in a row while `req[2]` is pending.
4. **Request drop and data change mid-transaction.**
   - Stimulus: `req[3]` is granted with `req_data[3]`=8'h07; `req[3]` deasserts and `req_data[3]` changes to 8'hFF during WAIT.
   - Required: `done[3]` still pulses; `result` equals `model`(8'h07).
5. **Reset mid-transaction.**
   - Stimulus: `rst_n` pulsed low in the WAIT cycle.
   - Required: all outputs are 0 before the next edge; no `done` appears; after release with `req`=4'b1001, requester 0 is granted first.
6. **SETTLE=1 boundary.**
   - Stimulus: SETTLE=1, `req[2]` held continuously.
   - Required: `done[2]` pulses every 2 cycles; `gnt[2]` is low in each `done` cycle and re-asserted at the following edge.

Source files
------------

// File: rtl/model_arbiter.sv
// Round-robin arbiter sharing one combinational `model` datapath among NREQ requesters.
// The granted operand is held for SETTLE cycles, then model_out is captured and returned.
module model_arbiter #(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned SETTLE = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   req_data,
  output logic [NREQ-1:0]         gnt,
  output logic [NREQ-1:0]         done,
  output logic [WIDTH-1:0]        result,
  output logic                    busy,
  output logic [WIDTH-1:0]        model_in,
  input  logic [WIDTH-1:0]        model_out
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {StIdle, StWait} state_e;

  state_e          state_q;
  logic [IW-1:0]   ptr_q;
  logic [IW-1:0]   win_q;
  logic [3:0]      cnt_q;
  logic [IW-1:0]   win;
  logic [NREQ-1:0] win_oh;

  // First set request at or above ptr, wrapping; descending scan so the lowest offset wins.
  always_comb begin
    win = '0;
    for (int k = int'(NREQ) - 1; k >= 0; k--) begin
      if (req[(int'(ptr_q) + k) % int'(NREQ)]) begin
        win = IW'((int'(ptr_q) + k) % int'(NREQ));
      end
    end
  end

  always_comb begin
    win_oh = '0;
    win_oh[win] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      ptr_q    <= '0;
      win_q    <= '0;
      cnt_q    <= '0;
      gnt      <= '0;
      done     <= '0;
      result   <= '0;
      busy     <= 1'b0;
      model_in <= '0;
    end else begin
      done <= '0;
      unique case (state_q)
        StIdle: begin
          if (|req) begin
            gnt      <= win_oh;
            win_q    <= win;
            model_in <= req_data[int'(win)*WIDTH +: WIDTH];
            cnt_q    <= 4'(SETTLE);
            busy     <= 1'b1;
            state_q  <= StWait;
          end
        end
        StWait: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            result  <= model_out;
            done    <= gnt;
            gnt     <= '0;
            busy    <= 1'b0;
            ptr_q   <= (win_q == IW'(NREQ - 1)) ? '0 : win_q + IW'(1);
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_model_arbiter.sv
// Self-checking bench for model_arbiter: directed scenarios plus random traffic
// compared against a transaction-level round-robin reference model.
module tb_model_arbiter;

  logic        clk, rst_n;
  logic [3:0]  req, gnt, done;
  logic [31:0] req_data;
  logic [7:0]  result, model_in, model_out;
  logic        busy;

  logic [3:0]  req1, gnt1, done1;
  logic [31:0] req_data1;
  logic [7:0]  result1, model_in1, model_out1;
  logic        busy1;

  int checks = 0;
  int errors = 0;

  // Reference model state: active requester (-1 none), edges left, pointer, etc.
  int         m_ptr, m_act, m_left, m_done;
  logic [7:0] m_min, m_result;
  int         gq[$];
  logic [3:0] prev_gnt;

  function automatic logic [7:0] fmodel(input logic [7:0] x);
    return ({x[6:0], 1'b0} + x) ^ 8'h5A;
  endfunction

  assign model_out  = fmodel(model_in);
  assign model_out1 = fmodel(model_in1);

  model_arbiter #(.NREQ(4), .WIDTH(8), .SETTLE(2)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .gnt(gnt), .done(done),
    .result(result), .busy(busy), .model_in(model_in), .model_out(model_out)
  );

  model_arbiter #(.NREQ(4), .WIDTH(8), .SETTLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req1), .req_data(req_data1), .gnt(gnt1), .done(done1),
    .result(result1), .busy(busy1), .model_in(model_in1), .model_out(model_out1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic mdl_reset();
    m_ptr = 0; m_act = -1; m_left = 0; m_done = -1;
    m_min = 8'h00; m_result = 8'h00; prev_gnt = 4'b0;
  endtask

  // Applies the rules for one rising edge given the inputs currently presented.
  task automatic mdl_update();
    m_done = -1;
    if (m_act < 0) begin
      if (req != 4'b0) begin
        for (int k = 0; k < 4; k++) begin
          if (m_act < 0 && req[(m_ptr + k) % 4]) m_act = (m_ptr + k) % 4;
        end
        m_min  = req_data[m_act*8 +: 8];
        m_left = 2;
      end
    end else begin
      m_left--;
      if (m_left == 0) begin
        m_result = fmodel(m_min);
        m_done   = m_act;
        m_ptr    = (m_act + 1) % 4;
        m_act    = -1;
      end
    end
  endtask

  task automatic tick();
    int eg, ed;
    mdl_update();
    @(posedge clk);
    @(negedge clk);
    eg = (m_act < 0) ? 0 : (1 << m_act);
    ed = (m_done < 0) ? 0 : (1 << m_done);
    chk("gnt", 32'(gnt), 32'(eg));
    chk("done", 32'(done), 32'(ed));
    chk("busy", 32'(busy), (m_act >= 0) ? 32'd1 : 32'd0);
    chk("model_in", 32'(model_in), 32'(m_min));
    chk("result", 32'(result), 32'(m_result));
    if (gnt != 4'b0 && prev_gnt == 4'b0) begin
      for (int i = 0; i < 4; i++) if (gnt[i]) gq.push_back(i);
    end
    prev_gnt = gnt;
  endtask

  initial begin
    clk = 0; rst_n = 1; req = '0; req_data = '0; req1 = '0; req_data1 = {4{8'h33}};
    mdl_reset();
    #1 rst_n = 0;
    #2;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_model_in", 32'(model_in), 32'd0);
    @(negedge clk);
    rst_n = 1;

    // All four requesters held: grants 0,1,2,3,0 at edges 0,3,6,9,12.
    gq.delete();
    req = 4'b1111; req_data = {8'h04, 8'h03, 8'h02, 8'h01};
    for (int i = 0; i < 15; i++) tick();
    chk("rr_count", 32'(gq.size()), 32'd5);
    for (int i = 0; i < 5 && i < gq.size(); i++) chk("rr_order", 32'(gq[i]), 32'(i % 4));
    req = '0;
    for (int i = 0; i < 3; i++) tick();

    // Single request from requester 1.
    req = 4'b0010; req_data = 32'h0000_0500;
    tick();
    chk("single_gnt", 32'(gnt), 32'h2);
    chk("single_min", 32'(model_in), 32'h05);
    req = '0;
    tick();
    chk("single_busy1", 32'(busy), 32'd1);
    tick();
    chk("single_done", 32'(done), 32'h2);
    chk("single_res", 32'(result), 32'(fmodel(8'h05)));
    chk("single_busy2", 32'(busy), 32'd0);
    tick();
    chk("single_done_off", 32'(done), 32'h0);

    // Fairness: req[0] held, req[2] joins one cycle later.
    gq.delete();
    req = 4'b0001; req_data = {8'h40, 8'h30, 8'h20, 8'h10};
    tick();
    req = 4'b0101;
    for (int i = 0; i < 11; i++) tick();
    chk("fair_count", 32'(gq.size()), 32'd4);
    for (int i = 0; i < 4 && i < gq.size(); i++) chk("fair_order", 32'(gq[i]), (i % 2) ? 32'd2 : 32'd0);
    req = '0;
    for (int i = 0; i < 3; i++) tick();

    // Request dropped and operand changed while the transaction is in flight.
    req = 4'b1000; req_data = 32'h0700_0000;
    tick();
    req = '0; req_data = 32'hFF00_0000;
    tick();
    tick();
    chk("drop_done", 32'(done), 32'h8);
    chk("drop_res", 32'(result), 32'(fmodel(8'h07)));
    tick();

    // Reset in the WAIT cycle aborts without a done; arbitration restarts at 0.
    req = 4'b0100; req_data = 32'h0099_0000;
    tick();
    #1 rst_n = 0;
    #1;
    chk("abort_gnt", 32'(gnt), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_min", 32'(model_in), 32'd0);
    chk("abort_res", 32'(result), 32'd0);
    mdl_reset();
    req = 4'b1001; req_data = {8'h11, 8'h22, 8'h33, 8'h44};
    #1 rst_n = 1;
    tick();
    chk("abort_regrant", 32'(gnt), 32'h1);
    req = '0;
    for (int i = 0; i < 3; i++) tick();
    chk("abort_nodone_ptr", 32'(m_ptr), 32'd1);

    // Random traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      req      = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      req_data = $urandom;
      tick();
    end
    req = '0;
    for (int i = 0; i < 3; i++) tick();

    // SETTLE=1: lone persistent requester completes every two cycles.
    req1 = 4'b0100;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i % 2 == 0) begin
        chk("s1_gnt_on", 32'(gnt1), 32'h4);
        chk("s1_done_off", 32'(done1), 32'h0);
      end else begin
        chk("s1_gnt_off", 32'(gnt1), 32'h0);
        chk("s1_done_on", 32'(done1), 32'h4);
        chk("s1_res", 32'(result1), 32'(fmodel(8'h33)));
      end
    end
    req1 = '0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
